seg_scan_ctrl: RTL

- Time-multiplexed scan controller for the 4-digit 7-segment display of the vending machine.
- Drives the 2-bit select input of the 2-to-4 active-low digit-enable decoder and presents the BCD nibble for the selected digit to the segment encoder.
- Adds inter-digit blanking (anti-ghosting), leading-zero suppression and a tear-free value-update handshake.

---
 rtl/seg_scan_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment scan controller with inter-digit
// blanking, leading-zero suppression and frame-aligned value updates.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  output logic        upd_ready,
  output logic [1:0]  digit_sel,
  output logic [3:0]  digit_val,
  output logic        seg_blank,
  output logic        frame_done
);

  localparam int M1 =
    (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int MC = (M1 > 2) ? M1 : 2;
  localparam int CW = $clog2(MC);
  localparam bit NO_GAP = (BLANK_CYC == 0);
  localparam logic [CW-1:0] RD_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BC_LAST =
    CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, n_state;
  logic [CW-1:0] cnt, n_cnt;
  logic [1:0]    n_sel;
  logic [15:0]   active, n_act;
  logic [15:0]   pending, n_pend;
  logic          pend_v, n_pv;
  logic          adv;

  function automatic logic [3:0] nib(
    input logic [15:0] a,
    input logic [1:0]  d
  );
    logic [3:0] r;
    unique case (d)
      2'd3: r = a[15:12];
      2'd2: r = a[11:8];
      2'd1: r = a[7:4];
      2'd0: r = a[3:0];
    endcase
    return r;
  endfunction

  // digit 0 is never suppressed so a zero value still reads "0"
  function automatic logic lz(
    input logic [15:0] a,
    input logic [1:0]  d
  );
    logic r;
    unique case (d)
      2'd3: r = (a[15:12] == 4'h0);
      2'd2: r = (a[15:8] == 8'h00);
      2'd1: r = (a[15:4] == 12'h000);
      2'd0: r = 1'b0;
    endcase
    return (LZ_SUPPRESS != 0) && r;
  endfunction

  function automatic logic bnd(
    input state_t        st,
    input logic [1:0]    s,
    input logic [CW-1:0] c
  );
    if (NO_GAP)
      return (st == SHOW) && (s == 2'd0) && (c == RD_LAST);
    return (st == GAP) && (s == 2'd0) && (c == BC_LAST);
  endfunction

  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_sel   = digit_sel;
    n_act   = active;
    n_pend  = pending;
    n_pv    = pend_v;
    adv     = 1'b0;
    if (state == IDLE) begin
      n_cnt = '0;
      n_sel = 2'd3;
      if (pend_v) begin
        n_act = pending;
        n_pv  = 1'b0;
      end
      if (en) n_state = SHOW;
    end else if (!en) begin
      n_state = IDLE;
      n_cnt   = '0;
      n_sel   = 2'd3;
    end else begin
      unique case (state)
        SHOW: begin
          if (cnt == RD_LAST) begin
            if (NO_GAP) begin
              adv = 1'b1;
            end else begin
              n_state = GAP;
              n_cnt   = '0;
            end
          end else begin
            n_cnt = cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == BC_LAST) adv = 1'b1;
          else n_cnt = cnt + CW'(1);
        end
        default: ;
      endcase
      if (adv) begin
        n_state = SHOW;
        n_cnt   = '0;
        n_sel   = digit_sel - 2'd1;
        // frame boundary: swap in the staged value untorn
        if (digit_sel == 2'd0 && pend_v) begin
          n_act = pending;
          n_pv  = 1'b0;
        end
      end
    end
    if (upd_valid && !pend_v) begin
      n_pend = upd_data;
      n_pv   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      active     <= '0;
      pending    <= '0;
      pend_v     <= 1'b0;
      digit_sel  <= 2'd3;
      digit_val  <= 4'h0;
      seg_blank  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= n_state;
      cnt        <= n_cnt;
      active     <= n_act;
      pending    <= n_pend;
      pend_v     <= n_pv;
      digit_sel  <= n_sel;
      digit_val  <= nib(n_act, n_sel);
      seg_blank  <= (n_state != SHOW) | lz(n_act, n_sel);
      frame_done <= bnd(n_state, n_sel, n_cnt);
    end
  end

  assign upd_ready = ~pend_v;

endmodule
